// File: rtl/chip8_gpu.sv
// CHIP-8 sprite engine: XOR-draws an N-line sprite into the memory-resident
// 64x32 framebuffer over a shared read-handshake / write-strobe memory port.
module chip8_gpu #(
  parameter logic [11:0] FB_BASE = 12'h100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        draw,
  input  logic [11:0] addr,
  input  logic [3:0]  lines,
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  output logic        busy,
  output logic        collision,
  output logic        mem_read,
  output logic [11:0] mem_read_idx,
  input  logic [7:0]  mem_read_byte,
  input  logic        mem_read_ack,
  output logic        mem_write,
  output logic [11:0] mem_write_idx,
  output logic [7:0]  mem_write_byte
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_READ_L, S_WRITE_L, S_READ_R, S_WRITE_R
  } state_t;

  state_t      r_state, w_next;
  logic [11:0] r_addr;
  logic [3:0]  r_lines, r_row;
  logic [5:0]  r_x;
  logic [4:0]  r_y;
  logic [7:0]  r_sprite, r_old;
  logic        r_acc, r_collision, r_busy, r_hold;

  logic [5:0]  w_py;
  logic        w_row_end, w_rd_done, w_clip_r;
  logic [15:0] w_shift;
  logic [11:0] w_addr_l, w_addr_r;

  assign w_py      = {1'b0, r_y} + {2'b00, r_row};
  assign w_row_end = (r_row == r_lines) | w_py[5];
  assign w_shift   = {r_sprite, 8'h00} >> r_x[2:0];
  assign w_addr_l  = FB_BASE + {4'b0000, w_py[4:0], 3'b000} + {9'd0, r_x[5:3]};
  assign w_addr_r  = w_addr_l + 12'd1;
  assign w_clip_r  = (r_x[5:3] == 3'd7);
  assign w_rd_done = mem_read & mem_read_ack;

  assign busy      = r_busy;
  assign collision = r_collision;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (draw) w_next = S_FETCH;
      S_FETCH:   if (w_row_end) w_next = S_IDLE;
                 else if (w_rd_done) w_next = S_READ_L;
      S_READ_L:  if (w_rd_done) w_next = S_WRITE_L;
      S_WRITE_L: w_next = w_clip_r ? S_FETCH : S_READ_R;
      S_READ_R:  if (w_rd_done) w_next = S_WRITE_R;
      S_WRITE_R: w_next = S_FETCH;
      default:   w_next = S_IDLE;
    endcase
  end

  // r_hold drops mem_read for one cycle after every ack, so back-to-back
  // reads (FETCH -> READ_L) still show a deasserted request between them.
  always_comb begin
    mem_read       = 1'b0;
    mem_read_idx   = '0;
    mem_write      = 1'b0;
    mem_write_idx  = '0;
    mem_write_byte = '0;
    case (r_state)
      S_FETCH: begin
        mem_read     = ~w_row_end & ~r_hold;
        mem_read_idx = r_addr + {8'd0, r_row};
      end
      S_READ_L: begin
        mem_read     = ~r_hold;
        mem_read_idx = w_addr_l;
      end
      S_WRITE_L: begin
        mem_write      = 1'b1;
        mem_write_idx  = w_addr_l;
        mem_write_byte = r_old ^ w_shift[15:8];
      end
      S_READ_R: begin
        mem_read     = ~r_hold;
        mem_read_idx = w_addr_r;
      end
      S_WRITE_R: begin
        mem_write      = 1'b1;
        mem_write_idx  = w_addr_r;
        mem_write_byte = r_old ^ w_shift[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_lines     <= '0;
      r_row       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_sprite    <= '0;
      r_old       <= '0;
      r_acc       <= 1'b0;
      r_collision <= 1'b0;
      r_busy      <= 1'b0;
      r_hold      <= 1'b0;
    end else begin
      r_hold <= w_rd_done;
      case (r_state)
        S_IDLE: if (draw) begin
          r_addr  <= addr;
          r_lines <= lines;
          r_x     <= x;
          r_y     <= y;
          r_row   <= '0;
          r_acc   <= 1'b0;
          r_busy  <= 1'b1;
        end
        S_FETCH: begin
          if (w_row_end) begin
            r_busy      <= 1'b0;
            r_collision <= r_acc;
          end else if (w_rd_done) begin
            r_sprite <= mem_read_byte;
          end
        end
        S_READ_L, S_READ_R: if (w_rd_done) r_old <= mem_read_byte;
        S_WRITE_L: begin
          r_acc <= r_acc | (|(r_old & w_shift[15:8]));
          if (w_clip_r) r_row <= r_row + 4'd1;
        end
        S_WRITE_R: begin
          r_acc <= r_acc | (|(r_old & w_shift[7:0]));
          r_row <= r_row + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_gpu.sv
// Directed + random bench for chip8_gpu: behavioural memory with variable
// read latency, and a scoreboard of expected framebuffer writes.
module tb_chip8_gpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        draw = 1'b0;
  logic [11:0] addr = '0;
  logic [3:0]  lines = '0;
  logic [5:0]  x = '0;
  logic [4:0]  y = '0;
  logic        busy, collision, mem_read, mem_write;
  logic [11:0] mem_read_idx, mem_write_idx;
  logic [7:0]  mem_read_byte, mem_write_byte;
  logic        mem_read_ack;

  chip8_gpu #(.FB_BASE(12'h100)) dut (
    .clk(clk), .rst(rst), .draw(draw), .addr(addr), .lines(lines),
    .x(x), .y(y), .busy(busy), .collision(collision),
    .mem_read(mem_read), .mem_read_idx(mem_read_idx),
    .mem_read_byte(mem_read_byte), .mem_read_ack(mem_read_ack),
    .mem_write(mem_write), .mem_write_idx(mem_write_idx),
    .mem_write_byte(mem_write_byte)
  );

  always #5 clk = ~clk;

  typedef struct { logic [11:0] idx; logic [7:0] b; } wr_t;
  wr_t sb[$];

  logic [7:0] mem [0:4095];
  logic [7:0] ref_mem [0:4095];
  int lat = 1;
  int cnt = 0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: write commits on the strobe edge, reads ack after `lat` cycles.
  always @(posedge clk) begin
    if (mem_write) mem[mem_write_idx] = mem_write_byte;
    if (rst) begin
      mem_read_ack <= 1'b0;
      cnt <= 0;
    end else if (mem_read && !mem_read_ack) begin
      if (cnt >= lat - 1) begin
        mem_read_ack  <= 1'b1;
        mem_read_byte <= mem[mem_read_idx];
        cnt <= 0;
      end else cnt <= cnt + 1;
    end else begin
      mem_read_ack <= 1'b0;
      cnt <= 0;
    end
  end

  // Monitor: handshake rules and scoreboard pop, sampled on the falling edge.
  logic        prev_rd = 1'b0, prev_ack = 1'b0;
  logic [11:0] prev_idx = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read && mem_write) chk("rd_wr_overlap", {mem_read, mem_write}, 2'b10);
      if (prev_rd && !prev_ack) begin
        chk("rd_held", mem_read, 1'b1);
        chk("rd_idx_stable", mem_read_idx, prev_idx);
      end
      if (mem_write) begin
        chk("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          wr_t w;
          w = sb.pop_front();
          chk("wr_idx", mem_write_idx, w.idx);
          chk("wr_byte", mem_write_byte, w.b);
        end
      end
    end
    prev_rd  = mem_read & ~rst;
    prev_ack = mem_read_ack;
    prev_idx = mem_read_idx;
  end

  task automatic model_draw(input logic [11:0] a, input logic [3:0] n,
                            input logic [5:0] xx, input logic [4:0] yy,
                            output logic coll);
    logic [15:0] sh;
    logic [11:0] ba;
    logic [7:0]  old;
    int py;
    coll = 1'b0;
    for (int r = 0; r < int'(n); r++) begin
      py = int'(yy) + r;
      if (py >= 32) break;
      sh = {ref_mem[a + 12'(r)], 8'h00} >> xx[2:0];
      ba = 12'h100 + 12'(py * 8) + 12'(xx[5:3]);
      old = ref_mem[ba];
      if ((old & sh[15:8]) != 0) coll = 1'b1;
      ref_mem[ba] = old ^ sh[15:8];
      sb.push_back('{idx: ba, b: old ^ sh[15:8]});
      if (xx[5:3] != 3'd7) begin
        old = ref_mem[ba + 12'd1];
        if ((old & sh[7:0]) != 0) coll = 1'b1;
        ref_mem[ba + 12'd1] = old ^ sh[7:0];
        sb.push_back('{idx: ba + 12'd1, b: old ^ sh[7:0]});
      end
    end
  endtask

  // ign >= 0: pulse a conflicting draw that many cycles into the busy window.
  task automatic do_draw(input logic [11:0] a, input logic [3:0] n,
                         input logic [5:0] xx, input logic [4:0] yy,
                         input int ign, output logic c);
    int k;
    @(negedge clk);
    draw = 1'b1; addr = a; lines = n; x = xx; y = yy;
    model_draw(a, n, xx, yy, c);
    @(negedge clk);
    draw = 1'b0;
    chk("busy_rise", busy, 1'b1);
    k = 0;
    while (busy && k < 2000) begin
      if (k == ign) begin
        draw = 1'b1; x = 6'd32; y = 5'd10;
      end else draw = 1'b0;
      @(negedge clk);
      k++;
    end
    draw = 1'b0;
    chk("busy_fall_in_time", busy, 1'b0);
    chk("collision", collision, c);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic clear_fb();
    for (int unsigned i = 12'h100; i <= 12'h2FF; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
  endtask

  initial begin
    logic c;
    int bad;
    for (int unsigned i = 0; i < 4096; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    for (int unsigned i = 0; i < 12'h100; i++) begin
      mem[i] = 8'($urandom_range(0, 255));
      ref_mem[i] = mem[i];
    end
    mem[12'h42] = 8'hFF; mem[12'h43] = 8'hC3; mem[12'h44] = 8'hC3;
    mem[12'h45] = 8'hC3; mem[12'h46] = 8'hFF;
    for (int unsigned i = 12'h42; i <= 12'h46; i++) ref_mem[i] = mem[i];

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_collision", collision, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_idx", {mem_read_idx, mem_write_idx, mem_write_byte}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_draw(12'h42, 4'd5, 6'd0, 5'd0, -1, c);
    chk("t1_100", mem[12'h100], 8'hFF);
    chk("t1_108", mem[12'h108], 8'hC3);
    chk("t1_118", mem[12'h118], 8'hC3);
    chk("t1_120", mem[12'h120], 8'hFF);
    chk("t1_coll", collision, 1'b0);

    do_draw(12'h42, 4'd5, 6'd0, 5'd0, -1, c);
    chk("t2_100", mem[12'h100], 8'h00);
    chk("t2_120", mem[12'h120], 8'h00);
    chk("t2_coll", collision, 1'b1);

    clear_fb();
    do_draw(12'h42, 4'd5, 6'd0, 5'd28, -1, c);
    chk("t3_1e0", mem[12'h1E0], 8'hFF);
    chk("t3_1f8", mem[12'h1F8], 8'hC3);
    chk("t3_200", mem[12'h200], 8'h00);
    chk("t3_coll", collision, 1'b0);

    clear_fb();
    lat = 3;
    do_draw(12'h42, 4'd5, 6'd5, 5'd0, -1, c);
    chk("t4_row0", {mem[12'h100], mem[12'h101]}, 16'h07F8);
    chk("t4_row2", {mem[12'h110], mem[12'h111]}, 16'h0618);
    chk("t4_row4", {mem[12'h120], mem[12'h121]}, 16'h07F8);
    chk("t4_coll", collision, 1'b0);

    lat = 1;
    do_draw(12'h42, 4'd5, 6'd5, 5'd0, -1, c);
    chk("t5_erase_coll", collision, 1'b1);
    do_draw(12'h42, 4'd5, 6'd61, 5'd0, -1, c);
    chk("t5_107", mem[12'h107], 8'h07);
    chk("t5_10f", mem[12'h10F], 8'h06);
    chk("t5_127", mem[12'h127], 8'h07);
    chk("t5_noright", {mem[12'h108], mem[12'h110], mem[12'h118], mem[12'h120]}, 32'd0);
    chk("t5_128", mem[12'h128], 8'h00);
    chk("t5_coll", collision, 1'b0);

    do_draw(12'h42, 4'd0, 6'd0, 5'd0, -1, c);
    chk("lines0_coll", collision, 1'b0);
    do_draw(12'h42, 4'd5, 6'd0, 5'd31, -1, c);
    chk("y31_1f8", mem[12'h1F8], 8'hFF);

    clear_fb();
    do_draw(12'h42, 4'd5, 6'd0, 5'd0, 3, c);
    chk("ign_154", mem[12'h154], 8'h00);
    chk("ign_120", mem[12'h120], 8'hFF);

    clear_fb();
    @(negedge clk);
    draw = 1'b1; addr = 12'h42; lines = 4'd5; x = 6'd0; y = 5'd0;
    model_draw(12'h42, 4'd5, 6'd0, 5'd0, c);
    @(negedge clk);
    draw = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rd", mem_read, 1'b0);
    chk("abort_wr", mem_write, 1'b0);
    sb.delete();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_quiet", {mem_read, mem_write}, 2'b00);
    end
    chk("abort_kept_100", mem[12'h100], 8'hFF);
    chk("abort_kept_108", mem[12'h108], 8'hC3);
    chk("abort_no_118", mem[12'h118], 8'h00);

    clear_fb();
    for (int i = 0; i < 8; i++) begin
      lat = int'($urandom_range(1, 4));
      do_draw(12'($urandom_range(0, 12'hF0)), 4'($urandom_range(0, 15)),
              6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), -1, c);
    end
    bad = 0;
    for (int unsigned i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
